// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants for the CPU front end.
// Imported by the IF->ID stage and its helpers.
package cpu_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/perf_ctr.sv
// Free-running wrap-around event counter.
// Used by if_id_skid_stage when IF_ID_PERF_EN is defined.
module perf_ctr
  import cpu_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  output logic [XLEN-1:0] cnt_o
);

  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID stage: registered-ready skid buffer with flush bubble.
// IF_ID_PERF_EN adds stall_cnt/flush_cnt counters.
module if_id_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int                PC_W            = 32,
  parameter int                INST_W          = 32,
  parameter logic [INST_W-1:0] NOP_INST        = cpu_pipe_pkg::NOP_INST,
  parameter bit                BUBBLE_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              m_v_q, m_v_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [INST_W-1:0] m_inst_q, m_inst_d;
  logic              s_v_q, s_v_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [INST_W-1:0] s_inst_q, s_inst_d;

  logic accept;
  logic main_free;

  assign accept    = in_valid & ~s_v_q;
  assign main_free = ~m_v_q | out_ready;

  always_comb begin
    m_v_d    = m_v_q;
    m_pc_d   = m_pc_q;
    m_inst_d = m_inst_q;
    s_v_d    = s_v_q;
    s_pc_d   = s_pc_q;
    s_inst_d = s_inst_q;
    if (flush) begin
      s_v_d    = 1'b0;
      m_v_d    = BUBBLE_ON_FLUSH;
      m_pc_d   = in_pc;
      m_inst_d = NOP_INST;
    end else if (main_free) begin
      // in_ready is low whenever skid is full, so no accept here
      if (s_v_q) begin
        m_v_d    = 1'b1;
        m_pc_d   = s_pc_q;
        m_inst_d = s_inst_q;
        s_v_d    = 1'b0;
      end else begin
        m_v_d    = accept;
        m_pc_d   = in_pc;
        m_inst_d = in_inst;
      end
    end else if (accept) begin
      s_v_d    = 1'b1;
      s_pc_d   = in_pc;
      s_inst_d = in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_pc_q   <= '0;
      m_inst_q <= NOP_INST;
      s_v_q    <= 1'b0;
      s_pc_q   <= '0;
      s_inst_q <= NOP_INST;
    end else begin
      m_v_q    <= m_v_d;
      m_pc_q   <= m_pc_d;
      m_inst_q <= m_inst_d;
      s_v_q    <= s_v_d;
      s_pc_q   <= s_pc_d;
      s_inst_q <= s_inst_d;
    end
  end

  assign in_ready  = ~s_v_q;
  assign out_valid = m_v_q;
  assign out_pc    = m_pc_q;
  assign out_inst  = m_inst_q;

`ifdef IF_ID_PERF_EN
  perf_ctr u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (m_v_q & ~out_ready),
    .cnt_o (stall_cnt)
  );

  perf_ctr u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule
